// File: rtl/bcd_xs3_word_seq.sv
// Serial BCD to Excess-3 word converter.
// One shared digit stage, LSD first, start/ready handshake.
module bcd_xs3_word_seq #(
    parameter int NDIG = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [4*NDIG-1:0] bcd_in,
    output logic              ready,
    output logic              busy,
    output logic [4*NDIG-1:0] xs3_out,
    output logic              valid,
    output logic              err
);

    localparam int W  = 4 * NDIG;
    localparam int CW = (NDIG > 1) ? $clog2(NDIG) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_CONV,
        S_DONE
    } state_t;

    state_t          state_q;
    logic [W-1:0]    sh_q;
    logic [W-1:0]    res_q;
    logic [W-1:0]    res_d;
    logic [W-1:0]    xs3_q;
    logic [CW-1:0]   cnt_q;
    logic            valid_q;
    logic            err_q;
    logic            ready_q;
    logic            busy_q;
    logic [3:0]      digit_w;
    logic [3:0]      nib_w;
    logic            bad_w;
    logic            last_w;

    // Shared digit stage: converts slot 0 and merges it into the partial word
    always_comb begin
        digit_w = sh_q[3:0];
        bad_w   = (digit_w > 4'd9);
        nib_w   = bad_w ? 4'd0 : (digit_w + 4'd3);
        last_w  = (cnt_q == CW'(NDIG - 1));
        res_d   = res_q;
        res_d[int'(cnt_q)*4 +: 4] = nib_w;
    end

    // Controller FSM with registered handshake and result outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            sh_q    <= '0;
            res_q   <= '0;
            xs3_q   <= '0;
            cnt_q   <= '0;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
            ready_q <= 1'b1;
            busy_q  <= 1'b0;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    if (start) begin
                        sh_q    <= bcd_in;
                        res_q   <= '0;
                        cnt_q   <= '0;
                        err_q   <= 1'b0;
                        ready_q <= 1'b0;
                        busy_q  <= 1'b1;
                        state_q <= S_CONV;
                    end
                end
                S_CONV: begin
                    res_q <= res_d;
                    sh_q  <= sh_q >> 4;
                    cnt_q <= cnt_q + CW'(1);
                    if (bad_w) begin
                        err_q <= 1'b1;
                    end
                    if (last_w) begin
                        xs3_q   <= res_d;
                        valid_q <= 1'b1;
                        cnt_q   <= '0;
                        state_q <= S_DONE;
                    end
                end
                S_DONE: begin
                    valid_q <= 1'b0;
                    ready_q <= 1'b1;
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign ready   = ready_q;
    assign busy    = busy_q;
    assign xs3_out = xs3_q;
    assign valid   = valid_q;
    assign err     = err_q;

endmodule

// File: tb/tb_bcd_xs3_word_seq.sv
// Bench for bcd_xs3_word_seq: scoreboard plus arithmetic reference model.
// Main instance NDIG=4, small directed instance NDIG=1.
module tb_bcd_xs3_word_seq;

    typedef struct {
        logic [15:0] x;
        logic        e;
        int          acc;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [15:0] bcd_in = '0;
    logic        ready, busy, valid, err;
    logic [15:0] xs3_out;

    logic        start1 = 1'b0;
    logic [3:0]  bcd1 = '0;
    logic        ready1, busy1, valid1, err1;
    logic [3:0]  xs3_1;

    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    exp_t sb[$];

    bcd_xs3_word_seq #(.NDIG(4)) dut (
        .clk(clk), .rst(rst), .start(start), .bcd_in(bcd_in),
        .ready(ready), .busy(busy), .xs3_out(xs3_out),
        .valid(valid), .err(err)
    );

    bcd_xs3_word_seq #(.NDIG(1)) dut1 (
        .clk(clk), .rst(rst), .start(start1), .bcd_in(bcd1),
        .ready(ready1), .busy(busy1), .xs3_out(xs3_1),
        .valid(valid1), .err(err1)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)",
                     name, act, req, cyc);
        end
    endtask

    // Reference: each digit independently d+3, or 0 with error flag
    function automatic exp_t model(input logic [15:0] w, input int acc);
        exp_t r;
        int   d;
        r.x = '0;
        r.e = 1'b0;
        r.acc = acc;
        for (int i = 0; i < 4; i++) begin
            d = (int'(w) >> (4 * i)) & 15;
            if (d <= 9) r.x = r.x | 16'((d + 3) << (4 * i));
            else r.e = 1'b1;
        end
        return r;
    endfunction

    // Called at a negedge; returns at the negedge after the accept edge
    task automatic send(input logic [15:0] w, input bit push);
        int t = 0;
        while (!ready && t < 100) begin
            @(negedge clk);
            t++;
        end
        chk("ready_timeout", int'(ready), 1);
        bcd_in = w;
        start = 1'b1;
        if (push) sb.push_back(model(w, cyc + 1));
        @(negedge clk);
        start = 1'b0;
        bcd_in = 16'($urandom);
    endtask

    task automatic wait_idle();
        int t = 0;
        while ((!ready || sb.size() != 0) && t < 200) begin
            @(negedge clk);
            t++;
        end
        chk("drain_timeout", int'(sb.size()), 0);
    endtask

    function automatic logic [15:0] rand_word();
        logic [15:0] w;
        if ($urandom_range(0, 1) == 1) begin
            w = '0;
            for (int i = 0; i < 4; i++)
                w[4*i +: 4] = 4'($urandom_range(0, 9));
        end else begin
            w = 16'($urandom);
        end
        return w;
    endfunction

    // Monitor: every valid pulse must match the oldest expectation
    always @(negedge clk) begin
        exp_t e;
        if (!rst && valid) begin
            if (sb.size() == 0) begin
                chk("unexpected_valid", 1, 0);
            end else begin
                e = sb.pop_front();
                chk("xs3_out", int'(xs3_out), int'(e.x));
                chk("err", int'(err), int'(e.e));
                chk("latency", cyc - e.acc, 4);
                chk("busy_in_done", int'(busy), 1);
                chk("ready_in_done", int'(ready), 0);
            end
        end
    end

    initial begin
        int prev;
        logic [15:0] w;

        repeat (2) @(negedge clk);
        rst = 1'b0;
        chk("rst_ready", int'(ready), 1);
        chk("rst_busy", int'(busy), 0);
        chk("rst_valid", int'(valid), 0);
        chk("rst_err", int'(err), 0);
        chk("rst_xs3", int'(xs3_out), 0);

        send(16'h1234, 1);
        chk("busy_after_accept", int'(busy), 1);
        chk("ready_after_accept", int'(ready), 0);
        wait_idle();
        send(16'h9999, 1);
        send(16'h0000, 1);
        send(16'h12A4, 1);
        wait_idle();
        repeat (3) @(negedge clk);
        chk("err_held", int'(err), 1);
        chk("xs3_held", int'(xs3_out), 16'h4507);
        send(16'h0001, 1);
        chk("err_cleared", int'(err), 0);
        wait_idle();

        // Start held high: accepts every six cycles, bcd_in churn ignored
        prev = -1;
        start = 1'b1;
        for (int k = 0; k < 30; k++) begin
            if (ready) begin
                bcd_in = 16'h0505;
                sb.push_back(model(16'h0505, cyc + 1));
                if (prev >= 0) chk("accept_period", cyc + 1 - prev, 6);
                prev = cyc + 1;
            end else begin
                bcd_in = 16'($urandom);
            end
            @(negedge clk);
        end
        start = 1'b0;
        wait_idle();

        // Abort in the second CONV cycle
        send(16'h8765, 0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("abort_ready", int'(ready), 1);
        chk("abort_busy", int'(busy), 0);
        chk("abort_xs3", int'(xs3_out), 0);
        chk("abort_valid", int'(valid), 0);
        repeat (6) @(negedge clk);
        send(16'h0042, 1);
        wait_idle();
        chk("after_abort_xs3", int'(xs3_out), 16'h3375);

        // Random traffic with stray starts while busy
        for (int n = 0; n < 40; n++) begin
            w = rand_word();
            send(w, 1);
            if ($urandom_range(0, 2) == 0) begin
                start = 1'b1;
                bcd_in = 16'($urandom);
                @(negedge clk);
                start = 1'b0;
            end
            repeat ($urandom_range(0, 3)) @(negedge clk);
        end
        wait_idle();

        // Single-digit instance
        start1 = 1'b1;
        bcd1 = 4'h7;
        @(negedge clk);
        start1 = 1'b0;
        bcd1 = 4'h2;
        chk("n1_valid_early", int'(valid1), 0);
        @(negedge clk);
        chk("n1_valid", int'(valid1), 1);
        chk("n1_xs3_7", int'(xs3_1), 4'hA);
        chk("n1_err_7", int'(err1), 0);
        @(negedge clk);
        chk("n1_ready", int'(ready1), 1);
        start1 = 1'b1;
        bcd1 = 4'hF;
        @(negedge clk);
        start1 = 1'b0;
        @(negedge clk);
        chk("n1_valid_f", int'(valid1), 1);
        chk("n1_xs3_f", int'(xs3_1), 0);
        chk("n1_err_f", int'(err1), 1);

        repeat (3) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
